// File: rtl/nete_rx_pkt_reader.sv
// nete_rx_pkt_reader: drains the IPCS descriptor FIFO and the 256-bit packet
// data FIFO, framing good packets onto a sop/eop stream and silently
// discarding bad or oversize ones so both FIFOs stay aligned.
//
// state | meaning
// IDLE  | waiting for a descriptor; read strobe issued when one is present
// HDR   | descriptor word valid; decode byte count and flags
// DATA  | reading data words into the skid buffer and streaming them out
// DROP  | reading and discarding the data words of a rejected packet
module nete_rx_pkt_reader #(
  parameter int MAX_BCNT = 9600,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      ipcs_data,
  input  logic             ipcs_empty,
  output logic             ipcs_rden,
  input  logic [255:0]     pkt_data,
  input  logic             pkt_empty,
  output logic             pkt_rden,
  output logic [255:0]     m_data,
  output logic             m_valid,
  output logic             m_sop,
  output logic             m_eop,
  output logic [5:0]       m_bytes,
  input  logic             m_ready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

  state_t       state, state_nx;
  logic [11:0]  words_q;
  logic [5:0]   last_bytes_q;
  logic [11:0]  issued;
  logic [11:0]  out_idx;
  logic [255:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   occ;
  logic         infl;

  logic [15:0]  hdr_bcnt;
  logic         hdr_bad, hdr_over;
  logic [16:0]  hdr_sum;
  logic [11:0]  hdr_words;
  logic [5:0]   hdr_last;
  logic         xfer, head_last, rd_data, rd_drop;
  logic [2:0]   pend;
  logic         ipcs_rd, pkt_done, drop_done;
  logic         unused_desc;

  assign hdr_bcnt    = ipcs_data[15:0];
  assign hdr_bad     = ipcs_data[16];
  assign unused_desc = ^ipcs_data[63:17];
  assign hdr_over    = 32'(hdr_bcnt) > 32'(MAX_BCNT);
  assign hdr_sum     = {1'b0, hdr_bcnt} + 17'd31;
  assign hdr_words   = hdr_sum[16:5];
  assign hdr_last    = (hdr_bcnt[4:0] == 5'd0) ? 6'd32 : {1'b0, hdr_bcnt[4:0]};

  assign m_valid   = (state == DATA) && (occ != 2'd0);
  assign xfer      = m_valid && m_ready;
  assign head_last = (out_idx == words_q - 12'd1);
  assign m_data    = mem[rd_ptr];
  assign m_sop     = m_valid && (out_idx == 12'd0);
  assign m_eop     = m_valid && head_last;
  assign m_bytes   = !m_valid ? 6'd0 : (head_last ? last_bytes_q : 6'd32);

  // A word popped this cycle frees its slot, so the read credit counts it;
  // this is what lets the stream sustain one word per cycle.
  assign pend      = {1'b0, occ} + {2'b00, infl} - {2'b00, xfer};
  assign rd_data   = (state == DATA) && (issued < words_q) && !pkt_empty && (pend < 3'd2);
  assign rd_drop   = (state == DROP) && (issued < words_q) && !pkt_empty;
  assign pkt_rden  = rd_data | rd_drop;
  assign ipcs_rden = ipcs_rd & ~rst;
  assign busy      = (state != IDLE);

  // Next-state decode and descriptor/packet completion strobes.
  always_comb begin
    state_nx  = state;
    ipcs_rd   = 1'b0;
    pkt_done  = 1'b0;
    drop_done = 1'b0;
    case (state)
      IDLE: begin
        if (!ipcs_empty) begin
          ipcs_rd  = 1'b1;
          state_nx = HDR;
        end
      end
      HDR: begin
        if (hdr_bcnt == 16'd0) begin
          drop_done = 1'b1;
          state_nx  = IDLE;
        end else if (hdr_bad || hdr_over) begin
          state_nx = DROP;
        end else begin
          state_nx = DATA;
        end
      end
      DATA: begin
        if (xfer && head_last) begin
          pkt_done = 1'b1;
          if (!ipcs_empty) begin
            ipcs_rd  = 1'b1;
            state_nx = HDR;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DROP: begin
        if (rd_drop && (issued + 12'd1 == words_q)) begin
          drop_done = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, per-packet bookkeeping, skid buffer and statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      words_q      <= '0;
      last_bytes_q <= '0;
      issued       <= '0;
      out_idx      <= '0;
      mem[0]       <= '0;
      mem[1]       <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occ          <= '0;
      infl         <= 1'b0;
      pkt_cnt      <= '0;
      drop_cnt     <= '0;
    end else begin
      state <= state_nx;
      infl  <= rd_data;
      if (state == HDR) begin
        words_q      <= hdr_words;
        last_bytes_q <= hdr_last;
        issued       <= '0;
        out_idx      <= '0;
        occ          <= '0;
        wr_ptr       <= 1'b0;
        rd_ptr       <= 1'b0;
      end else begin
        if (pkt_rden) issued <= issued + 12'd1;
        if (infl) begin
          mem[wr_ptr] <= pkt_data;
          wr_ptr      <= ~wr_ptr;
        end
        if (xfer) begin
          rd_ptr  <= ~rd_ptr;
          out_idx <= out_idx + 12'd1;
        end
        occ <= occ + {1'b0, infl} - {1'b0, xfer};
      end
      if (pkt_done)  pkt_cnt  <= pkt_cnt + 1'b1;
      if (drop_done) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: doc/nete_rx_pkt_reader.md
Name: nete_rx_pkt_reader

Overview:
- Reader-side counterpart of the receive path's packet writer; drains the IPCS descriptor FIFO and the 256-bit packet-data FIFO that the receive engine fills.
- Per packet: pops one descriptor (byte count plus flags), then pops exactly ceil(bcnt/32) data words and presents them as a framed 256-bit stream (sop/eop/byte count) toward the OmniXtend core.
- Bad or oversize packets have their data words drained silently so the two FIFOs stay aligned.

Parameters:
- MAX_BCNT, 9600: largest legal packet in bytes; larger descriptors are dropped.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- ipcs_data  in  64  descriptor: [15:0] byte count, [16] bad-frame flag, [63:17] ignored.
- ipcs_empty  in  1  descriptor FIFO empty.
- ipcs_rden  out  1  descriptor FIFO read strobe.
- pkt_data  in  256  packet word; byte 0 is at [255:248].
- pkt_empty  in  1  data FIFO empty.
- pkt_rden  out  1  data FIFO read strobe.
- m_data  out  256  output word.
- m_valid  out  1  output word valid.
- m_sop  out  1  first word of packet.
- m_eop  out  1  last word of packet.
- m_bytes  out  6  valid bytes in word (1..32); 32 on non-eop words.
- m_ready  in  1  downstream accept.
- pkt_cnt  out  CNT_W  packets delivered (wraps).
- drop_cnt  out  CNT_W  packets dropped (wraps).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; ipcs_rden=0, pkt_rden=0, m_valid=0, m_sop=0, m_eop=0, m_bytes=0, m_data=0, pkt_cnt=0, drop_cnt=0, busy=0; skid buffer emptied; in-flight reads forgotten. FIFO contents are untouched. Reset mid-packet abandons the packet.
- FIFO read latency is 1 cycle: data is valid the cycle after rden. Strobes are never issued while the FIFO is empty.
- IDLE: if !ipcs_empty, pulse ipcs_rden for 1 cycle, then go to HDR.
- HDR (descriptor data valid):
  - Capture bcnt; words = (bcnt+31)>>5; last_bytes = (bcnt[4:0]==0) ? 32 : bcnt[4:0].
  - If flag[16]=1, or bcnt==0, or bcnt>MAX_BCNT: go to DROP. Exception: bcnt==0 consumes no data words, goes straight to IDLE, and increments drop_cnt.
  - Otherwise go to DATA.
- DATA:
  - Assert pkt_rden when words_issued<words, !pkt_empty, and (skid occupancy + in-flight read) < 2.
  - Returned words enter a 2-entry skid buffer; the head drives m_*.
  - m_sop marks word 0; m_eop and m_bytes=last_bytes mark word words-1.
  - A word transfers when m_valid && m_ready. m_data, m_sop, m_eop and m_bytes hold stable while m_valid && !m_ready.
  - Sustains 1 word/cycle with m_ready held high.
  - After the eop transfer: pkt_cnt++, go to IDLE. The next descriptor read may begin the same cycle the eop transfers.
- DROP:
  - Issue pkt_rden whenever !pkt_empty until words reads have been issued; m_valid stays 0.
  - After the last read: drop_cnt++, go to IDLE.
- Single-word packet (bcnt 1..32): m_sop=m_eop=1 on the same word.
- Counters wrap modulo 2^CNT_W.
- pkt_empty during DATA/DROP stalls reads only; no timeout.

Test Plan:
- Descriptor bcnt=64, two words A,B preloaded, m_ready=1 -> A (sop, bytes=32) then B (eop, bytes=32) on consecutive cycles; pkt_cnt=1.
- bcnt=70 -> 3 words; third word has eop=1, m_bytes=6; exactly 3 pkt_rden pulses total.
- bcnt=40 with flag[16]=1, followed by a good bcnt=32 packet -> 2 words drained, no m_valid during the drop; drop_cnt=1; the good packet emits one word with sop=eop=1, bytes=32.
- bcnt=9601 and bcnt=0 descriptors -> drop_cnt=2; 301 words drained for the 9601 case, 0 words for the 0 case.
- bcnt=128 with m_ready toggling 1010… and pkt_empty asserted for 3 cycles mid-packet -> 4 words in order, outputs stable while stalled, no duplicate or skipped words, skid never overflows.
- rst pulsed 2 words into a 5-word packet -> all outputs zero asynchronously; after release, the FSM is IDLE and the next descriptor is read.
